// File: rtl/siren_pattern_gen.sv
// N-channel lamp bar / siren / colour pattern generator driven by a slow tick strobe.
// Optional soft stop (freeze lamps until next tick) enabled by defining SIREN_SOFT_STOP_EN.
module siren_pattern_gen #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned ON_TICKS = 1,
  parameter int unsigned BURST    = 2,
  parameter int unsigned GAP      = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable_siren,
  input  logic              tick,
  input  logic [1:0]        mode,
  output logic              siren,
  output logic              color,
  output logic [NUM_CH-1:0] lamp
);

`ifdef SIREN_SOFT_STOP_EN
  typedef enum logic [1:0] {IDLE, ACTIVE, STOPPING} state_t;
`else
  typedef enum logic [1:0] {IDLE, ACTIVE} state_t;
`endif

  typedef enum logic [1:0] {M_STEADY, M_ALT, M_ROTATE, M_BURST} mode_t;

  localparam logic [CNT_W-1:0] PH_LAST     = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] ROT_LAST    = CNT_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] BURST_LAST  = CNT_W'(2 * BURST + GAP - 1);
  localparam logic [CNT_W-1:0] BURST_FLASH = CNT_W'(2 * BURST);

  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic             tick_q;
  logic [CNT_W-1:0] ph_q, ph_d;
  logic [CNT_W-1:0] step_q, step_d;
  logic             color_q, color_d;
  logic             tick_edge;
  logic             last_step;

  assign tick_edge = tick & ~tick_q;

  always_comb begin
    unique case (mode_q)
      M_STEADY: last_step = 1'b1;
      M_ALT:    last_step = step_q[0];
      M_ROTATE: last_step = (step_q == ROT_LAST);
      M_BURST:  last_step = (step_q == BURST_LAST);
      default:  last_step = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    ph_d    = ph_q;
    step_d  = step_q;
    color_d = color_q;
    unique case (state_q)
      IDLE: begin
        if (enable_siren) begin
          state_d = ACTIVE;
          mode_d  = mode_t'(mode);
          ph_d    = '0;
          step_d  = '0;
          color_d = 1'b0;
        end
      end
      ACTIVE: begin
        if (!enable_siren) begin
`ifdef SIREN_SOFT_STOP_EN
          state_d = STOPPING;
`else
          state_d = IDLE;
          ph_d    = '0;
          step_d  = '0;
          color_d = 1'b0;
`endif
        end else if (tick_edge) begin
          if (mode_t'(mode) != mode_q) begin
            mode_d  = mode_t'(mode);
            ph_d    = '0;
            step_d  = '0;
            color_d = 1'b0;
          end else if (ph_q == PH_LAST) begin
            ph_d   = '0;
            step_d = last_step ? '0 : step_q + 1'b1;
            // ALT colour follows the step; ROTATE/BURST colour flips once per full period
            unique case (mode_q)
              M_STEADY: color_d = 1'b0;
              M_ALT:    color_d = step_d[0];
              default:  color_d = last_step ? ~color_q : color_q;
            endcase
          end else begin
            ph_d = ph_q + 1'b1;
          end
        end
      end
`ifdef SIREN_SOFT_STOP_EN
      STOPPING: begin
        if (enable_siren) begin
          state_d = ACTIVE;
          mode_d  = mode_t'(mode);
          ph_d    = '0;
          step_d  = '0;
          color_d = 1'b0;
        end else if (tick_edge) begin
          state_d = IDLE;
          ph_d    = '0;
          step_d  = '0;
          color_d = 1'b0;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mode_q  <= M_STEADY;
      tick_q  <= 1'b0;
      ph_q    <= '0;
      step_q  <= '0;
      color_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      tick_q  <= tick;
      ph_q    <= ph_d;
      step_q  <= step_d;
      color_q <= color_d;
    end
  end

  // Outputs decode straight from registers; in STOPPING the frozen step keeps lamps steady
  always_comb begin
    lamp = '0;
    if (state_q != IDLE) begin
      unique case (mode_q)
        M_STEADY: lamp = '1;
        M_ALT: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            lamp[i] = step_q[0] ? (i >= NUM_CH / 2) : (i < NUM_CH / 2);
          end
        end
        M_ROTATE: begin
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            lamp[i] = (step_q == CNT_W'(i));
          end
        end
        M_BURST: begin
          if ((step_q < BURST_FLASH) && !step_q[0]) lamp = '1;
        end
        default: lamp = '0;
      endcase
    end
  end

  assign siren = (state_q == ACTIVE);
  assign color = color_q;

endmodule

// File: tb/tb_siren_pattern_gen.sv
// Self-checking bench for siren_pattern_gen: directed vector table, hand sequences, random vs model.
module tb_siren_pattern_gen;

  localparam int unsigned NUM_CH   = 4;
  localparam int unsigned ON_TICKS = 1;
  localparam int unsigned BURST    = 2;
  localparam int unsigned GAP      = 2;
  localparam int unsigned CNT_W    = 8;

  logic              clock;
  logic              reset;
  logic              enable_siren;
  logic              tick;
  logic [1:0]        mode;
  logic              siren;
  logic              color;
  logic [NUM_CH-1:0] lamp;

  siren_pattern_gen #(
    .NUM_CH  (NUM_CH),
    .ON_TICKS(ON_TICKS),
    .BURST   (BURST),
    .GAP     (GAP),
    .CNT_W   (CNT_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .enable_siren(enable_siren),
    .tick        (tick),
    .mode        (mode),
    .siren       (siren),
    .color       (color),
    .lamp        (lamp)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Reference model: counts tick edges since the last (re)start and derives outputs arithmetically
  int m_st;        // 0 idle, 1 active, 2 stopping
  int m_mode;
  int m_t;
  bit m_prev_tick;

  function automatic void m_reset();
    m_st = 0; m_mode = 0; m_t = 0; m_prev_tick = 1'b0;
  endfunction

  function automatic void m_update(input bit en, input bit tk, input int md);
    bit edge_seen;
    edge_seen   = tk && !m_prev_tick;
    m_prev_tick = tk;
    case (m_st)
      0: if (en) begin m_st = 1; m_mode = md; m_t = 0; end
      1: begin
        if (!en) begin
`ifdef SIREN_SOFT_STOP_EN
          m_st = 2;
`else
          m_st = 0; m_t = 0;
`endif
        end else if (edge_seen) begin
          if (md != m_mode) begin m_mode = md; m_t = 0; end
          else m_t++;
        end
      end
      default: begin
        if (en) begin m_st = 1; m_mode = md; m_t = 0; end
        else if (edge_seen) begin m_st = 0; m_t = 0; end
      end
    endcase
  endfunction

  function automatic void m_out(output bit s, output bit c, output bit [NUM_CH-1:0] l);
    int k, p, x;
    bit [NUM_CH-1:0] lower;
    lower = '0;
    for (int i = 0; i < NUM_CH / 2; i++) lower[i] = 1'b1;
    s = (m_st == 1);
    c = 1'b0;
    l = '0;
    if (m_st != 0) begin
      k = m_t / ON_TICKS;
      case (m_mode)
        0: l = '1;
        1: begin x = k % 2; l = x ? (lower << (NUM_CH / 2)) : lower; c = bit'(x); end
        2: begin x = k % NUM_CH; l = '0; l[x] = 1'b1; c = bit'((k / NUM_CH) % 2); end
        default: begin
          p = 2 * BURST + GAP;
          x = k % p;
          l = (x < 2 * BURST && x % 2 == 0) ? '1 : '0;
          c = bit'((k / p) % 2);
        end
      endcase
    end
  endfunction

  // One clock: inputs are changed only at posedge+1, outputs sampled at posedge+1
  task automatic cyc(input bit en, input bit tk, input bit [1:0] md);
    enable_siren = en; tick = tk; mode = md;
    @(posedge clock);
    if (!reset) m_reset();
    else m_update(en, tk, int'(md));
    #1;
  endtask

  task automatic chk_out(input string name, input bit s, input bit c, input bit [NUM_CH-1:0] l);
    chk({name, ".siren"}, int'(siren), int'(s));
    chk({name, ".color"}, int'(color), int'(c));
    chk({name, ".lamp"},  int'(lamp),  int'(l));
  endtask

  typedef struct {
    bit              en;
    bit              tk;
    bit [1:0]        md;
    bit              s;
    bit              c;
    bit [NUM_CH-1:0] l;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input bit en, input bit tk, input bit [1:0] md,
                              input bit s, input bit c, input bit [NUM_CH-1:0] l);
    vec_t v;
    v.en = en; v.tk = tk; v.md = md; v.s = s; v.c = c; v.l = l;
    vecs.push_back(v);
  endfunction

  // A 1-cycle tick pulse followed by a low cycle; outputs hold after the edge
  function automatic void add_tick(input bit [1:0] md, input bit c, input bit [NUM_CH-1:0] l);
    add(1'b1, 1'b1, md, 1'b1, c, l);
    add(1'b1, 1'b0, md, 1'b1, c, l);
  endfunction

  bit              ms, mc;
  bit [NUM_CH-1:0] ml;
  bit              r_en, r_tk;
  bit [1:0]        r_md;

  initial begin
    // Directed table: ALT, held tick, mode switch to BURST, BURST cycle, ROTATE cycle
    add(1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 4'b0000);
    add(1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 4'b0011);
    add_tick(2'd1, 1'b1, 4'b1100);
    add_tick(2'd1, 1'b0, 4'b0011);
    add_tick(2'd1, 1'b1, 4'b1100);
    add_tick(2'd1, 1'b0, 4'b0011);
    for (int i = 0; i < 5; i++) add(1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 4'b1100);
    add(1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 4'b1100);
    add(1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 4'b1100);
    add_tick(2'd3, 1'b0, 4'b1111);
    add_tick(2'd3, 1'b0, 4'b0000);
    add_tick(2'd3, 1'b0, 4'b1111);
    add_tick(2'd3, 1'b0, 4'b0000);
    add_tick(2'd3, 1'b0, 4'b0000);
    add_tick(2'd3, 1'b0, 4'b0000);
    add_tick(2'd3, 1'b1, 4'b1111);
    add(1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 4'b1111);
    add_tick(2'd2, 1'b0, 4'b0001);
    add_tick(2'd2, 1'b0, 4'b0010);
    add_tick(2'd2, 1'b0, 4'b0100);
    add_tick(2'd2, 1'b0, 4'b1000);
    add_tick(2'd2, 1'b1, 4'b0001);
    add_tick(2'd2, 1'b1, 4'b0010);

    reset = 1'b0; enable_siren = 1'b0; tick = 1'b0; mode = 2'd0;
    m_reset();
    #1;
    chk_out("reset", 1'b0, 1'b0, 4'b0000);
    cyc(1'b1, 1'b0, 2'd1);
    cyc(1'b1, 1'b1, 2'd1);
    chk_out("reset_hold", 1'b0, 1'b0, 4'b0000);
    reset = 1'b1;

    foreach (vecs[i]) begin
      cyc(vecs[i].en, vecs[i].tk, vecs[i].md);
      chk_out($sformatf("vec%0d", i), vecs[i].s, vecs[i].c, vecs[i].l);
    end

    // Disable while ALT shows 1100
    cyc(1'b1, 1'b1, 2'd1);
    chk_out("dis_alt0", 1'b1, 1'b0, 4'b0011);
    cyc(1'b1, 1'b0, 2'd1);
    cyc(1'b1, 1'b1, 2'd1);
    chk_out("dis_alt1", 1'b1, 1'b1, 4'b1100);
    cyc(1'b0, 1'b0, 2'd1);
`ifdef SIREN_SOFT_STOP_EN
    chk_out("stop_freeze", 1'b0, 1'b1, 4'b1100);
    cyc(1'b0, 1'b0, 2'd1);
    chk_out("stop_hold", 1'b0, 1'b1, 4'b1100);
    cyc(1'b0, 1'b1, 2'd1);
    chk_out("stop_tick", 1'b0, 1'b0, 4'b0000);
    cyc(1'b1, 1'b0, 2'd1);
    cyc(1'b1, 1'b1, 2'd1);
    chk_out("stop_pre", 1'b1, 1'b1, 4'b1100);
    cyc(1'b0, 1'b0, 2'd1);
    chk_out("stop_again", 1'b0, 1'b1, 4'b1100);
    cyc(1'b1, 1'b0, 2'd1);
    chk_out("stop_reen", 1'b1, 1'b0, 4'b0011);
`else
    chk_out("dis_now", 1'b0, 1'b0, 4'b0000);
    cyc(1'b0, 1'b1, 2'd1);
    chk_out("dis_idle", 1'b0, 1'b0, 4'b0000);
    cyc(1'b1, 1'b1, 2'd1);
    chk_out("start_tick_ignored", 1'b1, 1'b0, 4'b0011);
`endif

    // Asynchronous reset pulse mid-pattern, between clock edges
    cyc(1'b1, 1'b0, 2'd3);
    cyc(1'b1, 1'b1, 2'd3);
    chk_out("pre_rst", 1'b1, 1'b0, 4'b1111);
    #3 reset = 1'b0;
    m_reset();
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 2'd3);
    reset = 1'b1;
    cyc(1'b0, 1'b1, 2'd3);
    chk_out("post_rst0", 1'b0, 1'b0, 4'b0000);
    cyc(1'b0, 1'b0, 2'd3);
    chk_out("post_rst1", 1'b0, 1'b0, 4'b0000);
    cyc(1'b1, 1'b0, 2'd0);
    chk_out("restart", 1'b1, 1'b0, 4'b1111);

    // Random stimulus against the model
    r_md = 2'd1;
    for (int i = 0; i < 600; i++) begin
      r_en = ($urandom_range(0, 19) != 0);
      r_tk = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) r_md = 2'($urandom_range(0, 3));
      cyc(r_en, r_tk, r_md);
      m_out(ms, mc, ml);
      chk_out($sformatf("rnd%0d", i), ms, mc, ml);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
